// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out handshake bundle for the 3x3 window generator.
// slave is the generator's view; master is the frame reader / filter side.
interface window_gen_3x3_if #(
    parameter int DW = 8
);
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] win0, win1, win2;
    logic [DW-1:0] win3, win4, win5;
    logic [DW-1:0] win6, win7, win8;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic          frame_done;

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8,
        output win_valid, win_last, frame_done
    );

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
        input  win_valid, win_last, frame_done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 neighbourhood windows using two WIDTH-deep line buffers.
// Latency: window for pixel (r,c) valid the cycle after that pixel is accepted.
// Backpressure: single output stage; pix_ready drops while a window is pending and unconsumed.
module window_gen_3x3 #(
    parameter int WIDTH  = 300,
    parameter int HEIGHT = 400,
    parameter int DW     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    window_gen_3x3_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] lb1 [WIDTH];
    logic [DW-1:0] lb2 [WIDTH];
    logic [DW-1:0] w   [9];
    logic          win_valid_q;
    logic          win_last_q;
    logic          frame_done_q;

    logic accept;
    logic col_last;
    logic row_last;

    assign bus.pix_ready = !win_valid_q || bus.win_ready;
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign col_last      = (col == CW'(WIDTH - 1));
    assign row_last      = (row == RW'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col          <= '0;
            row          <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                w[k] <= '0;
            end
        end else begin
            frame_done_q <= accept && col_last && row_last;
            if (accept) begin
                // Each window row shifts left; the new column enters from the line buffers.
                w[0] <= w[1];
                w[1] <= w[2];
                w[2] <= lb2[col];
                w[3] <= w[4];
                w[4] <= w[5];
                w[5] <= lb1[col];
                w[6] <= w[7];
                w[7] <= w[8];
                w[8] <= bus.pix_in;
                win_valid_q <= (row >= RW'(2)) && (col >= CW'(2));
                win_last_q  <= col_last && row_last;
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) begin
                    row <= row_last ? '0 : row + RW'(1);
                end
            end else if (bus.win_ready) begin
                win_valid_q <= 1'b0;
                win_last_q  <= 1'b0;
            end
        end
    end

    // Line buffers hold no reset: rows 0..1 of every frame overwrite them before any window uses them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= bus.pix_in;
        end
    end

    assign bus.win0       = w[0];
    assign bus.win1       = w[1];
    assign bus.win2       = w[2];
    assign bus.win3       = w[3];
    assign bus.win4       = w[4];
    assign bus.win5       = w[5];
    assign bus.win6       = w[6];
    assign bus.win7       = w[7];
    assign bus.win8       = w[8];
    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 5x4 instance for directed tests and a 40x30 instance for a full-frame count.
module tb_window_gen_3x3;
    localparam int DW = 8;
    localparam int WB = 9 * DW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic          pv  [2];
    logic          wr  [2];
    logic [DW-1:0] pin [2];
    int            n_win  [2];
    int            n_fd   [2];
    int            n_last [2];
    logic [WB-1:0] seen [$];
    logic [WB-1:0] big_first;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gd
        localparam int W = (g == 0) ? 5 : 40;
        localparam int H = (g == 0) ? 4 : 30;

        window_gen_3x3_if #(.DW(DW)) bus ();
        window_gen_3x3 #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign bus.pix_valid = pv[g];
        assign bus.pix_in    = pin[g];
        assign bus.win_ready = wr[g];

        // Model: stored image plus a queue of windows owed to the consumer.
        logic [DW-1:0] img [H][W];
        logic [WB-1:0] q [$];
        logic [WB-1:0] held;
        logic [WB-1:0] cur;
        logic [WB-1:0] ew;
        bit hold_chk = 0;
        bit fd_exp   = 0;
        int r = 0;
        int c = 0;

        always @(negedge clk) begin
            cur = {bus.win_last, bus.win0, bus.win1, bus.win2, bus.win3, bus.win4,
                   bus.win5, bus.win6, bus.win7, bus.win8};
            if (!rst_n) begin
                q.delete();
                r = 0;
                c = 0;
                fd_exp = 0;
                hold_chk = 0;
            end else begin
                chk("frame_done", WB'(bus.frame_done), WB'(fd_exp));
                chk("win_valid", WB'(bus.win_valid), WB'(q.size() != 0));
                chk("pix_ready", WB'(bus.pix_ready), WB'(q.size() == 0 || wr[g]));
                if (hold_chk) chk("held_window", cur, held);
                hold_chk = bus.win_valid && !bus.win_ready;
                held = cur;
                if (bus.win_valid && bus.win_ready && q.size() != 0) begin
                    ew = q.pop_front();
                    chk("window", cur, ew);
                    n_win[g]++;
                    if (bus.win_last) n_last[g]++;
                    if (g == 0) seen.push_back(cur);
                    else if (n_win[g] == 1) big_first = cur;
                end
                if (bus.frame_done) n_fd[g]++;
                fd_exp = 0;
                if (pv[g] && bus.pix_ready) begin
                    img[r][c] = pin[g];
                    if (r >= 2 && c >= 2)
                        q.push_back({(r == H - 1 && c == W - 1),
                                     img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                                     img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                                     img[r][c-2],   img[r][c-1],   img[r][c]});
                    fd_exp = (r == H - 1 && c == W - 1);
                    c++;
                    if (c == W) begin
                        c = 0;
                        r++;
                        if (r == H) r = 0;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 5x4 frame of pix = base + 10*r + c, optional valid gaps, optional 3-cycle stall at first window.
    task automatic run_small(input int base, input int gap_pct, input bit stall, input int stop_after);
        int  rr = 0;
        int  cc = 0;
        int  acc_n = 0;
        int  stalls = 0;
        int  guard = 0;
        bit  stalled = 0;
        bit  acc;
        while (rr < 4 && acc_n != stop_after) begin
            pv[0]  = ($urandom_range(0, 99) >= gap_pct);
            pin[0] = DW'(base + 10 * rr + cc);
            if (stall && !stalled && gd[0].bus.win_valid) begin
                stalled = 1;
                stalls  = 3;
            end
            wr[0] = (stalls == 0);
            @(negedge clk);
            acc = pv[0] && gd[0].bus.pix_ready;
            if (stalls > 0) begin
                chk("stall_pix_ready", WB'(gd[0].bus.pix_ready), '0);
                stalls--;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                acc_n++;
                cc++;
                if (cc == 5) begin
                    cc = 0;
                    rr++;
                end
            end
            guard++;
            if (guard > 1000) begin
                timeout("small_frame");
                break;
            end
        end
        pv[0] = 0;
        wr[0] = 1;
    endtask

    task automatic check_frame0(input string tag, input int s0);
        chk({tag, "_count"}, WB'(seen.size() - s0), WB'(6));
        if (seen.size() >= s0 + 6) begin
            chk({tag, "_first"}, seen[s0],
                {1'b0, 8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22});
            chk({tag, "_last"}, seen[s0 + 5],
                {1'b1, 8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34});
        end
    endtask

    initial begin
        int s0;
        int f0;
        int l0;
        int rr;
        int cc;
        int guard;
        bit acc;

        pv  = '{1'b0, 1'b0};
        wr  = '{1'b1, 1'b1};
        pin = '{8'd0, 8'd0};
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        chk("reset_windows", {gd[0].bus.win_last, gd[0].bus.win0, gd[0].bus.win1, gd[0].bus.win2,
                              gd[0].bus.win3, gd[0].bus.win4, gd[0].bus.win5, gd[0].bus.win6,
                              gd[0].bus.win7, gd[0].bus.win8}, '0);
        chk("reset_flags", WB'({gd[0].bus.win_valid, gd[0].bus.frame_done}), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 1: continuous stream
        s0 = seen.size(); f0 = n_fd[0]; l0 = n_last[0];
        run_small(0, 0, 0, -1);
        idle(4);
        check_frame0("t1", s0);
        chk("t1_frame_done", WB'(n_fd[0] - f0), WB'(1));
        chk("t1_win_last", WB'(n_last[0] - l0), WB'(1));

        // 2: random valid gaps
        s0 = seen.size();
        run_small(0, 40, 0, -1);
        idle(4);
        check_frame0("t2", s0);

        // 3: consumer stall at the first window
        s0 = seen.size();
        run_small(0, 0, 1, -1);
        idle(4);
        check_frame0("t3", s0);

        // 4: reset after 7 accepted pixels
        run_small(0, 0, 0, 7);
        rst_n = 1'b0;
        pv[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pv[0] = 1'b0;
        @(negedge clk);
        chk("t4_valid_after_reset", WB'(gd[0].bus.win_valid), '0);
        @(posedge clk);
        #1;
        s0 = seen.size();
        run_small(0, 0, 0, -1);
        idle(4);
        check_frame0("t4", s0);

        // 5: two frames back to back
        s0 = seen.size(); f0 = n_fd[0]; l0 = n_last[0];
        run_small(0, 0, 0, -1);
        run_small(100, 0, 0, -1);
        idle(4);
        chk("t5_count", WB'(seen.size() - s0), WB'(12));
        if (seen.size() >= s0 + 7)
            chk("t5_frame2_first", seen[s0 + 6],
                {1'b0, 8'd100, 8'd101, 8'd102, 8'd110, 8'd111, 8'd112, 8'd120, 8'd121, 8'd122});
        chk("t5_frame_done", WB'(n_fd[0] - f0), WB'(2));
        chk("t5_win_last", WB'(n_last[0] - l0), WB'(2));

        // 6: 40x30 frame, pix = (40*r + c) mod 256
        rr = 0; cc = 0; guard = 0;
        while (rr < 30) begin
            pv[1]  = 1'b1;
            pin[1] = DW'((40 * rr + cc) % 256);
            @(negedge clk);
            acc = gd[1].bus.pix_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                cc++;
                if (cc == 40) begin
                    cc = 0;
                    rr++;
                end
            end
            guard++;
            if (guard > 5000) begin
                timeout("big_frame");
                break;
            end
        end
        pv[1] = 1'b0;
        idle(4);
        chk("t6_count", WB'(n_win[1]), WB'(38 * 28));
        chk("t6_win_last", WB'(n_last[1]), WB'(1));
        chk("t6_frame_done", WB'(n_fd[1]), WB'(1));
        chk("t6_first", big_first,
            {1'b0, 8'd0, 8'd1, 8'd2, 8'd40, 8'd41, 8'd42, 8'd80, 8'd81, 8'd82});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
